fetch_unit: RTL and testbench

Instruction fetch front-end that sits directly upstream of the processor core's decode/execute stage. It owns the program counter and issues word reads to a fixed 1-cycle-latency instruction memory. Returned words are buffered, with their PCs, in a small queue and presented downstream through a valid/ready handshake. It accepts branch/jump redirects from the core and flushes all younger fetched work.

---
 rtl/proc_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, constants and fetch-entry type for the fetch front-end
package proc_pkg;

    localparam int XLEN    = 32;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and instruction handshake bundle
interface fetch_unit_if #(
    parameter int XLEN = 32
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic [XLEN-1:0] pc_out;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_out,
        input  imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_out,
        output imem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with flush, holds fetched {inst, pc} entries
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok = push & (count != CNT_W'(DEPTH));
    assign pop_ok  = pop & (count != '0);
    assign dout    = mem[rd_ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flush wins over a same-cycle push so nothing older survives a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, issue and drop control feeding a fetch queue toward decode
module fetch_unit #(
    parameter int              XLEN     = proc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = proc_pkg::RESET_PC,
    parameter int              DEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    import proc_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic              inflight;
    logic              drop;
    logic              issue;
    logic              push;
    logic              pop;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic [2*XLEN-1:0] head;

    // Issue only looks at registered occupancy, so inst_ready never reaches imem_req.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign issue     = reset & ~bus.redirect & (occupancy < (CNT_W + 1)'(DEPTH));
    assign push      = inflight & ~drop;
    assign pop       = ~empty & bus.inst_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= issue;
            drop     <= bus.redirect & inflight;
            if (issue) req_pc <= pc;
            if (bus.redirect) begin
                pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + XLEN'(PC_STEP);
            end
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({bus.imem_rdata, req_pc}),
        .pop   (pop),
        .flush (bus.redirect),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = ~empty;
    assign bus.inst       = empty ? '0 : head[2*XLEN-1:XLEN];
    assign bus.inst_pc    = empty ? '0 : head[XLEN-1:0];
    assign bus.pc_out     = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed-vector bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus0 ();
    fetch_unit_if #(.XLEN(32)) bus1 ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // 1-cycle latency instruction memory returning addr ^ KEY
    always @(posedge clk) begin
        if (bus0.imem_req) bus0.imem_rdata <= bus0.imem_addr ^ KEY;
        if (bus1.imem_req) bus1.imem_rdata <= bus1.imem_addr ^ KEY;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic ready);
        reset = 1'b0;
        bus0.redirect = 1'b0;
        bus0.redirect_pc = '0;
        tick();
        tick();
        reset = 1'b1;
        bus0.inst_ready = ready;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus0.inst_ready = 1'b1;
        tick();
        vectors++; if (bus0.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", bus0.imem_req); end
        vectors++; if (bus0.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", bus0.imem_addr); end
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus0.inst_valid); end
        vectors++; if (bus0.inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h want 0", bus0.inst); end
        vectors++; if (bus0.inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc: got %h want 0", bus0.inst_pc); end
        vectors++; if (bus1.pc_out !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL rst_pc_out1: got %h want fffffff8", bus1.pc_out); end
        vectors++; if (bus1.imem_addr !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL rst_addr1: got %h want fffffff8", bus1.imem_addr); end
    endtask

    task automatic test_free_run;
        logic [31:0] exp1 [4];
        exp1[0] = 32'hFFFF_FFF8; exp1[1] = 32'hFFFF_FFFC; exp1[2] = 32'h0000_0000; exp1[3] = 32'h0000_0004;
        start(1'b1);
        vectors++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin miscompares++; $display("FAIL fr_first_req: got %b/%h want 1/0", bus0.imem_req, bus0.imem_addr); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL fr_c1_valid: got %b want 0", bus0.inst_valid); end
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++; if (bus0.inst_valid !== 1'b1) begin miscompares++; $display("FAIL fr_valid[%0d]: got %b want 1", k, bus0.inst_valid); end
            vectors++; if (bus0.inst_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL fr_pc[%0d]: got %h want %h", k, bus0.inst_pc, 32'(4 * k)); end
            vectors++; if (bus0.inst !== (32'(4 * k) ^ KEY)) begin miscompares++; $display("FAIL fr_inst[%0d]: got %h want %h", k, bus0.inst, 32'(4 * k) ^ KEY); end
            if (k < 4) begin
                vectors++; if (bus1.inst_valid !== 1'b1 || bus1.inst_pc !== exp1[k]) begin miscompares++; $display("FAIL wrap_pc[%0d]: got %b/%h want 1/%h", k, bus1.inst_valid, bus1.inst_pc, exp1[k]); end
                vectors++; if (bus1.inst !== (exp1[k] ^ KEY)) begin miscompares++; $display("FAIL wrap_inst[%0d]: got %h want %h", k, bus1.inst, exp1[k] ^ KEY); end
            end
        end
    endtask

    task automatic test_backpressure;
        start(1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c >= 2) begin
                vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head[c%0d]: got %b/%h want 1/0", c, bus0.inst_valid, bus0.inst_pc); end
            end
        end
        vectors++; if (bus0.imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_stop: got %b want 0", bus0.imem_req); end
        vectors++; if (bus0.pc_out !== 32'h10) begin miscompares++; $display("FAIL bp_pc_out: got %h want 10", bus0.pc_out); end
        vectors++; if (bus0.inst !== KEY) begin miscompares++; $display("FAIL bp_head_inst: got %h want %h", bus0.inst, KEY); end
        bus0.inst_ready = 1'b1;
        #1;
        for (int j = 0; j < 8; j++) begin
            vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'(4 * j)) begin miscompares++; $display("FAIL bp_drain[%0d]: got %b/%h want 1/%h", j, bus0.inst_valid, bus0.inst_pc, 32'(4 * j)); end
            vectors++; if (bus0.inst !== (32'(4 * j) ^ KEY)) begin miscompares++; $display("FAIL bp_drain_inst[%0d]: got %h want %h", j, bus0.inst, 32'(4 * j) ^ KEY); end
            tick();
        end
    endtask

    task automatic test_redirect;
        start(1'b0);
        for (int c = 1; c <= 4; c++) tick();
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0103;
        #1;
        vectors++; if (bus0.imem_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_n: got %b want 0", bus0.imem_req); end
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h0) begin miscompares++; $display("FAIL rd_pre_head: got %b/%h want 1/0", bus0.inst_valid, bus0.inst_pc); end
        tick();
        bus0.redirect = 1'b0;
        bus0.inst_ready = 1'b1;
        #1;
        vectors++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h100) begin miscompares++; $display("FAIL rd_new_req: got %b/%h want 1/100", bus0.imem_req, bus0.imem_addr); end
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rd_flushed_n1: got %b want 0", bus0.inst_valid); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rd_flushed_n2: got %b want 0", bus0.inst_valid); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h100) begin miscompares++; $display("FAIL rd_n3_head: got %b/%h want 1/100", bus0.inst_valid, bus0.inst_pc); end
        vectors++; if (bus0.inst !== (32'h100 ^ KEY)) begin miscompares++; $display("FAIL rd_n3_inst: got %h want %h", bus0.inst, 32'h100 ^ KEY); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h104) begin miscompares++; $display("FAIL rd_n4_head: got %b/%h want 1/104", bus0.inst_valid, bus0.inst_pc); end
    endtask

    task automatic test_redirect_handshake;
        start(1'b1);
        for (int c = 1; c <= 5; c++) tick();
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0200;
        #1;
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'hC) begin miscompares++; $display("FAIL rh_head: got %b/%h want 1/c", bus0.inst_valid, bus0.inst_pc); end
        vectors++; if (bus0.imem_req !== 1'b0) begin miscompares++; $display("FAIL rh_req_n: got %b want 0", bus0.imem_req); end
        tick();
        bus0.redirect = 1'b0;
        #1;
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rh_n1_valid: got %b want 0", bus0.inst_valid); end
        vectors++; if (bus0.imem_addr !== 32'h200) begin miscompares++; $display("FAIL rh_n1_addr: got %h want 200", bus0.imem_addr); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rh_n2_valid: got %b want 0", bus0.inst_valid); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h200) begin miscompares++; $display("FAIL rh_n3_head: got %b/%h want 1/200", bus0.inst_valid, bus0.inst_pc); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h204) begin miscompares++; $display("FAIL rh_n4_head: got %b/%h want 1/204", bus0.inst_valid, bus0.inst_pc); end
    endtask

    task automatic test_async_reset;
        start(1'b0);
        for (int c = 1; c <= 10; c++) tick();
        vectors++; if (bus0.inst_valid !== 1'b1) begin miscompares++; $display("FAIL ar_full: got %b want 1", bus0.inst_valid); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid_drop: got %b want 0", bus0.inst_valid); end
        vectors++; if (bus0.imem_req !== 1'b0) begin miscompares++; $display("FAIL ar_req_drop: got %b want 0", bus0.imem_req); end
        vectors++; if (bus0.pc_out !== 32'h0) begin miscompares++; $display("FAIL ar_pc_out: got %h want 0", bus0.pc_out); end
        tick();
        tick();
        reset = 1'b1;
        bus0.inst_ready = 1'b1;
        #1;
        vectors++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin miscompares++; $display("FAIL ar_restart_req: got %b/%h want 1/0", bus0.imem_req, bus0.imem_addr); end
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL ar_c0_valid: got %b want 0", bus0.inst_valid); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b0) begin miscompares++; $display("FAIL ar_c1_valid: got %b want 0", bus0.inst_valid); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h0 || bus0.inst !== KEY) begin miscompares++; $display("FAIL ar_c2_head: got %b/%h/%h want 1/0/%h", bus0.inst_valid, bus0.inst_pc, bus0.inst, KEY); end
        tick();
        vectors++; if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== 32'h4) begin miscompares++; $display("FAIL ar_c3_head: got %b/%h want 1/4", bus0.inst_valid, bus0.inst_pc); end
    endtask

    initial begin
        reset = 1'b0;
        bus0.redirect = 1'b0;
        bus0.redirect_pc = '0;
        bus0.inst_ready = 1'b1;
        bus0.imem_rdata = '0;
        bus1.redirect = 1'b0;
        bus1.redirect_pc = '0;
        bus1.inst_ready = 1'b1;
        bus1.imem_rdata = '0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_redirect_handshake();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
